// File: rtl/router_pkt_fifo_if.sv
// ----------------------------------------------------------------------------
// router_pkt_fifo_if
// Bus bundle between a router output channel and its packet FIFO.
//
// Handshake: write_enb and read_enb are requests (valid). The matching
// readiness is !full for writes and !empty for reads. A word moves on the
// rising clock edge where request and readiness are both high. A request
// without readiness is dropped and has no effect. After an accepted read,
// data_out and data_valid are updated on that same edge, so the popped word
// is visible during the following cycle.
//
// Signals:
//   data_in, write_enb, lfd_state  write side (driven by master)
//   read_enb                       read request (driven by master)
//   full, empty                    combinational occupancy flags
//   data_out, data_valid, pkt_last registered read side
//   pkt_err                        sticky framing error
//   fill_level, almost_full        optional status; tied to 0 when disabled
//
// Modports: master = router side, slave = FIFO side.
// ----------------------------------------------------------------------------
interface router_pkt_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] data_in;
    logic              write_enb;
    logic              lfd_state;
    logic              read_enb;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              pkt_last;
    logic              pkt_err;
    logic [PW-1:0]     fill_level;
    logic              almost_full;

    modport master (
        output data_in, write_enb, lfd_state, read_enb,
        input  full, empty, data_out, data_valid, pkt_last, pkt_err,
               fill_level, almost_full
    );

    modport slave (
        input  data_in, write_enb, lfd_state, read_enb,
        output full, empty, data_out, data_valid, pkt_last, pkt_err,
               fill_level, almost_full
    );
endinterface

// File: rtl/router_pkt_fifo.sv
// ----------------------------------------------------------------------------
// router_pkt_fifo
// Packet-aware synchronous FIFO for a router output channel. Each entry holds
// {lfd_state, data}. The read side follows packet framing from the length
// field of each header word and flags the final (parity) word and framing
// errors (truncated packets, orphan words).
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous active-high, clears all state (highest priority)
//   soft_reset  synchronous channel flush, same clearing as reset
//   bus         router_pkt_fifo_if.slave (handshake described there)
//
// Build option: define RTR_FIFO_STATUS_EN to enable the fill_level and
// almost_full outputs. Without it both outputs are tied to 0.
// ----------------------------------------------------------------------------
module router_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int LEN_LSB   = 2,
    parameter int LEN_W     = 6,
    parameter int AF_MARGIN = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                soft_reset,
    router_pkt_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = LEN_W + 1;

    // Elaboration-time sanity check on the parameter set.
    if (DATA_W < LEN_LSB + LEN_W || AF_MARGIN > DEPTH || DEPTH < 4 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("router_pkt_fifo: illegal parameter combination");
    end

    logic [DATA_W:0]   mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     pkt_cnt;

    logic              wr_acc;
    logic              rd_acc;
    logic              flush;
    logic [DATA_W:0]   rd_word;
    logic              rd_hdr;
    logic [LEN_W-1:0]  rd_len;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign bus.full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign bus.empty = (wr_ptr == rd_ptr);

    assign flush  = reset || soft_reset;
    assign wr_acc = bus.write_enb && !bus.full;
    assign rd_acc = bus.read_enb && !bus.empty;

    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign rd_hdr  = rd_word[DATA_W];
    assign rd_len  = rd_word[LEN_LSB+LEN_W-1:LEN_LSB];

    // Storage is never cleared; resetting the pointers invalidates it.
    always_ff @(posedge clock) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pkt_cnt        <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.pkt_last   <= 1'b0;
            bus.pkt_err    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            bus.data_valid <= rd_acc;
            bus.pkt_last   <= 1'b0;
            if (rd_acc) begin
                rd_ptr       <= rd_ptr + PW'(1);
                bus.data_out <= rd_word[DATA_W-1:0];
                if (rd_hdr) begin
                    // Header: expect len payload words plus one parity word.
                    pkt_cnt <= CW'(rd_len) + CW'(1);
                    if (pkt_cnt != '0) begin
                        bus.pkt_err <= 1'b1;
                    end
                end else if (pkt_cnt != '0) begin
                    pkt_cnt      <= pkt_cnt - CW'(1);
                    bus.pkt_last <= (pkt_cnt == CW'(1));
                end else begin
                    // Word outside any packet.
                    bus.pkt_err <= 1'b1;
                end
            end
        end
    end

`ifdef RTR_FIFO_STATUS_EN
    logic [PW-1:0] fill;
    logic [PW-1:0] free_cnt;

    // Pointer difference modulo 2*DEPTH yields 0..DEPTH directly.
    assign fill            = wr_ptr - rd_ptr;
    assign free_cnt        = PW'(DEPTH) - fill;
    assign bus.fill_level  = fill;
    assign bus.almost_full = (free_cnt <= PW'(AF_MARGIN));
`else
    assign bus.fill_level  = '0;
    assign bus.almost_full = 1'b0;
`endif

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised, packet-aware synchronous FIFO for the router output channels; successor to the fixed 16x8 channel FIFO. Each entry stores a data word plus a header tag (lfd_state). The read side tracks packet boundaries from the header's length field and flags the last word and framing errors. Replaces tristated idle output with an explicit data_valid qualifier.

Parameters:
DATA_W, 8, data word width (>= LEN_LSB+LEN_W)
DEPTH, 16, entries; power of two, >= 4
LEN_LSB, 2, LSB position of payload-length field in header word
LEN_W, 6, width of payload-length field
AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN (feature only)

Ports:
clock  in  1  sole clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
soft_reset  in  1  synchronous channel flush (timeout from router FSM)
data_in  in  DATA_W  write data
write_enb  in  1  write request
lfd_state  in  1  tags the written word as packet header
read_enb  in  1  read request
full  out  1  combinational, no free entry
empty  out  1  combinational, no stored entry
data_out  out  DATA_W  registered read data
data_valid  out  1  data_out holds a word popped last cycle
pkt_last  out  1  with data_valid: word is final word (parity) of packet
pkt_err  out  1  sticky framing error
fill_level  out  clog2(DEPTH)+1  occupancy (feature only, else 0)
almost_full  out  1  (feature only, else 0)

Behaviour:
- Storage: DEPTH x (DATA_W+1), {lfd_state, data_in}. Pointers clog2(DEPTH)+1 bits, MSB is wrap bit. full = low bits equal and wrap bits differ; empty = pointers equal.
- Write accepted iff write_enb && !full; stores at wr_ptr, wr_ptr+1. Rejected writes are dropped, no state change.
- Read accepted iff read_enb && !empty; next cycle data_out = stored data, data_valid=1, rd_ptr+1. No accepted read: data_valid=0, data_out holds last value.
- Latency: a word written in cycle N is readable (empty low) in N+1; no write-to-read bypass. Read data appears one cycle after accepting edge.
- Simultaneous read+write: full/empty evaluated on pre-edge state; when full, read accepted, write rejected; when empty, write accepted, read rejected; otherwise both accepted, occupancy unchanged.
- Packet counter pkt_cnt (LEN_W+1 bits), updated on accepted reads only:
  - header word read: pkt_cnt = len+1 (payload words + parity), len = data[LEN_LSB+LEN_W-1:LEN_LSB]; if pkt_cnt != 0 beforehand, pkt_err set (truncated packet).
  - non-header read, pkt_cnt != 0: pkt_cnt-1; pkt_last=1 with that word when pkt_cnt was 1.
  - non-header read, pkt_cnt == 0: pkt_err set (orphan word), pkt_cnt stays 0.
  - header with len=0: pkt_cnt=1; next word is parity, flagged pkt_last.
- pkt_last only valid with data_valid; 0 otherwise.
- pkt_err sticky until reset or soft_reset.
- reset (priority over everything): pointers, pkt_cnt, data_out=0, data_valid=0, pkt_last=0, pkt_err=0; full=0, empty=1 next cycle.
- soft_reset (below reset, above read/write): same clearing as reset; concurrent read/write in that cycle ignored. Memory contents not cleared (pointers suffice).
- Reset mid-packet: partial packet discarded, no error raised.

Optional Feature:
RTR_FIFO_STATUS_EN: defined -> fill_level = wr_ptr - rd_ptr (modulo 2*DEPTH, range 0..DEPTH), almost_full = (DEPTH - fill_level) <= AF_MARGIN, both combinational. Undefined -> both ports tied 0, no subtractor synthesised; all other behaviour identical.

Test Plan:
- Reset then write header 0x0D (lfd=1), 0xA1,0xA2,0xA3, parity 0x5E; read 5 -> data_out 0x0D,A1,A2,A3,5E with data_valid, pkt_last only on 0x5E, pkt_err=0, empty=1 after.
- Write 16 words -> full=1 after 16th; 17th write (0xFF) dropped; read all 16 -> original order, 0xFF never appears; same-cycle read+write at full -> read accepted, write dropped.
- Empty FIFO, read_enb+write_enb same cycle with 0x33 -> data_valid=0 next cycle, empty=0; read next cycle -> 0x33.
- Header 0x0D read then header 0x08 read before 4 words consumed -> pkt_err=1 and stays 1; soft_reset -> pkt_err=0, empty=1, data_out=0.
- Non-header word 0x77 read with pkt_cnt=0 -> pkt_err=1; header 0x00 then 0x12 -> pkt_last on 0x12.
- With RTR_FIFO_STATUS_EN, write 14 words -> fill_level=14, almost_full=1; 13 words -> almost_full=0; without macro both read 0.
